// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file and rename table.
// Widths here match the commit bundle produced by the reorder buffer.
package reg_file_pkg;

    localparam int RF_REG_ADDR_WIDTH = 5;
    localparam int RF_Q_WIDTH        = 4;
    localparam int XLEN              = 32;
    localparam int NO_TAG            = 0;

endpackage

// File: rtl/reg_file_rf_read_port.sv
// One operand lookup: register value plus pending ROB tag, x0 forced to zero.
// With REGFILE_BYPASS_EN defined, a same-cycle commit of the awaited tag is forwarded.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int AW = RF_REG_ADDR_WIDTH,
    parameter int QW = RF_Q_WIDTH
) (
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] reg_val,
    input  logic [QW-1:0]   reg_tag,
    input  logic            reg_busy,
`ifdef REGFILE_BYPASS_EN
    input  logic            commit_fwd,
    input  logic [QW-1:0]   commit_q,
    input  logic [XLEN-1:0] commit_v,
`endif
    output logic [XLEN-1:0] v,
    output logic [QW-1:0]   q
);

    always_comb begin
        v = reg_val;
        q = reg_busy ? reg_tag : QW'(NO_TAG);
`ifdef REGFILE_BYPASS_EN
        if (reg_busy && commit_fwd && (reg_tag == commit_q)) begin
            v = commit_v;
            q = QW'(NO_TAG);
        end
`endif
        if (rs == '0) begin
            v = '0;
            q = QW'(NO_TAG);
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags; optional commit forwarding via REGFILE_BYPASS_EN.
// rdy_in is a global enable: state advances only when it is high, lookups are live regardless.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = RF_REG_ADDR_WIDTH,
    parameter int Q_WIDTH        = RF_Q_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear_in,
    input  logic                      has_issue,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [Q_WIDTH-1:0]        issue_Q,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [XLEN-1:0]           V1,
    output logic [XLEN-1:0]           V2,
    output logic [Q_WIDTH-1:0]        Q1,
    output logic [Q_WIDTH-1:0]        Q2,
    input  logic                      has_commit,
    input  logic                      commit_modify_regfile,
    input  logic [REG_ADDR_WIDTH-1:0] commit_reg_addr,
    input  logic [Q_WIDTH-1:0]        Commit_Q,
    input  logic [XLEN-1:0]           Commit_V
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [XLEN-1:0]    val  [NUM_REGS];
    logic [Q_WIDTH-1:0] tag  [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic commit_fwd;
    logic commit_wr;
    logic issue_wr;

    assign commit_fwd = has_commit && commit_modify_regfile;
    assign commit_wr  = commit_fwd && (commit_reg_addr != '0);
    assign issue_wr   = has_issue && (issue_rd != '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            // The retiring instruction is older than any flush, so its value always lands.
            if (commit_wr)
                val[commit_reg_addr] <= Commit_V;
            if (clear_in) begin
                for (int i = 0; i < NUM_REGS; i++)
                    tag[i] <= '0;
                busy <= '0;
            end else begin
                if (commit_wr && (tag[commit_reg_addr] == Commit_Q) &&
                    !(issue_wr && (issue_rd == commit_reg_addr)))
                    busy[commit_reg_addr] <= 1'b0;
                if (issue_wr) begin
                    tag[issue_rd]  <= issue_Q;
                    busy[issue_rd] <= 1'b1;
                end
            end
        end
    end

    rf_read_port #(.AW(REG_ADDR_WIDTH), .QW(Q_WIDTH)) u_port1 (
        .rs         (rs1),
        .reg_val    (val[rs1]),
        .reg_tag    (tag[rs1]),
        .reg_busy   (busy[rs1]),
`ifdef REGFILE_BYPASS_EN
        .commit_fwd (commit_fwd),
        .commit_q   (Commit_Q),
        .commit_v   (Commit_V),
`endif
        .v          (V1),
        .q          (Q1)
    );

    rf_read_port #(.AW(REG_ADDR_WIDTH), .QW(Q_WIDTH)) u_port2 (
        .rs         (rs2),
        .reg_val    (val[rs2]),
        .reg_tag    (tag[rs2]),
        .reg_busy   (busy[rs2]),
`ifdef REGFILE_BYPASS_EN
        .commit_fwd (commit_fwd),
        .commit_q   (Commit_Q),
        .commit_v   (Commit_V),
`endif
        .v          (V2),
        .q          (Q2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed scoreboard bench for reg_file; expectations are hand-computed per cycle.
// Build with REGFILE_BYPASS_EN defined to check the forwarding variant.
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        has_issue;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_Q;
    logic [4:0]  rs1, rs2;
    logic [31:0] V1, V2;
    logic [3:0]  Q1, Q2;
    logic        has_commit, commit_modify_regfile;
    logic [4:0]  commit_reg_addr;
    logic [3:0]  Commit_Q;
    logic [31:0] Commit_V;

    logic [71:0] exp_q[$];
    string       name_q[$];
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk_in = ~clk_in;

    reg_file dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .clear_in              (clear_in),
        .has_issue             (has_issue),
        .issue_rd              (issue_rd),
        .issue_Q               (issue_Q),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .V1                    (V1),
        .V2                    (V2),
        .Q1                    (Q1),
        .Q2                    (Q2),
        .has_commit            (has_commit),
        .commit_modify_regfile (commit_modify_regfile),
        .commit_reg_addr       (commit_reg_addr),
        .Commit_Q              (Commit_Q),
        .Commit_V              (Commit_V)
    );

    // Monitor: lookup outputs are presented whenever chk_en is raised.
    always @(negedge clk_in) begin
        if (chk_en) begin
            logic [71:0] got;
            logic [71:0] exp;
            string       nm;
            got = {V1, Q1, V2, Q2};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL underflow: output %h with no expectation", got);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got V1=%h Q1=%0d V2=%h Q2=%0d, expected V1=%h Q1=%0d V2=%h Q2=%0d",
                             nm, got[71:40], got[39:36], got[35:4], got[3:0],
                             exp[71:40], exp[39:36], exp[35:4], exp[3:0]);
                end
            end
        end
    end

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        has_issue = 1'b0; issue_rd = '0; issue_Q = '0;
        has_commit = 1'b0; commit_modify_regfile = 1'b0;
        commit_reg_addr = '0; Commit_Q = '0; Commit_V = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] q);
        has_issue = 1'b1; issue_rd = rd; issue_Q = q;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] q, input logic [31:0] v);
        has_commit = 1'b1; commit_modify_regfile = 1'b1;
        commit_reg_addr = rd; Commit_Q = q; Commit_V = v;
    endtask

    task automatic look(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] v1, input logic [3:0] q1,
                        input logic [31:0] v2, input logic [3:0] q2);
        rs1 = a1; rs2 = a2;
        exp_q.push_back({v1, q1, v2, q2});
        name_q.push_back(nm);
        chk_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        chk_en = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        rs1 = '0; rs2 = '0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        look("reset", 5, 0, 0, 0, 0, 0);
        tick();

        issue(3, 4);
        look("pre_issue", 5, 0, 0, 0, 0, 0);
        tick();

        commit(3, 4, 32'hDEAD);
`ifdef REGFILE_BYPASS_EN
        look("renamed_x3_bypass", 3, 0, 32'hDEAD, 0, 0, 0);
`else
        look("renamed_x3", 3, 0, 0, 4, 0, 0);
`endif
        tick();

        issue(3, 5);
        look("committed_x3", 3, 0, 32'hDEAD, 0, 0, 0);
        tick();

        commit(3, 4, 32'h7);
        look("rerenamed_x3", 3, 0, 32'hDEAD, 5, 0, 0);
        tick();

        issue(6, 9);
        commit(6, 8, 32'h1);
        look("stale_commit", 3, 6, 32'h7, 5, 0, 0);
        tick();

        issue(1, 1);
        look("rename_wins", 6, 3, 32'h1, 9, 32'h7, 5);
        tick();

        issue(2, 2);
        look("rename_x1", 1, 2, 0, 1, 0, 0);
        tick();

        clear_in = 1'b1;
        issue(1, 7);
        commit(5, 3, 32'h123);
        look("before_flush", 1, 2, 0, 1, 0, 2);
        tick();

        look("after_flush", 1, 3, 0, 0, 32'h7, 0);
        tick();

        rdy_in = 1'b0;
        issue(7, 6);
        commit(7, 6, 32'hAA);
        look("flush_commit_val", 6, 5, 32'h1, 0, 32'h123, 0);
        tick();

        issue(0, 3);
        commit(0, 3, 32'hFFFF);
        look("stall_held", 7, 6, 0, 0, 32'h1, 0);
        tick();

        issue(4, 3);
        look("x0_zero", 0, 0, 0, 0, 0, 0);
        tick();

        commit(4, 3, 32'h55);
`ifdef REGFILE_BYPASS_EN
        look("bypass_x4", 4, 5, 32'h55, 0, 32'h123, 0);
`else
        look("no_bypass_x4", 4, 5, 0, 3, 32'h123, 0);
`endif
        tick();

        issue(9, 2);
        look("committed_x4", 4, 3, 32'h55, 0, 32'h7, 0);
        tick();

        rst_in = 1'b1;
        look("renamed_x9", 9, 4, 0, 2, 32'h55, 0);
        tick();

        look("after_reset", 3, 9, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk_in);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
